noc_out_port_arbiter: RTL and testbench

Output-port arbiter and reader for the router input queues. One instance per router output port: it collects the routing requests that the five input queues raise for this port and grants one queue at a time with round-robin fairness. It issues pop requests to the granted queue, captures the returned flits into a 2-entry output buffer and presents them downstream with a valid/ready handshake.

---
 rtl/noc_out_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_noc_out_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_out_port_arbiter.sv
// Router output-port arbiter: round-robin grant over the input queues, pop issue, 2-entry flit buffer.
// Optional per-grant burst cap selected by `NOC_ARB_BURST_LIMIT_EN (uses MAX_BURST).
module noc_out_port_arbiter #(
    parameter int DATA_W    = 16,
    parameter int NUM_PORTS = 5,
    parameter int MAX_BURST = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_i,
    input  logic [NUM_PORTS-1:0]        en_i,
    input  logic [NUM_PORTS*DATA_W-1:0] data_i,
    output logic [NUM_PORTS-1:0]        pop_o,
    output logic [DATA_W-1:0]           data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [NUM_PORTS-1:0]        grant_o,
    output logic                        err_o
);
    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [IW-1:0]     src_q, src_d;
    logic              inflight_q, inflight_d;
    logic              armed_q;
    logic              err_q, err_d;
    logic [DATA_W-1:0] buf_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        cnt_q, cnt_d;

    logic [IW:0]          pick;
    logic [2:0]           load;
    logic                 credit;
    logic                 drain;
    logic                 pop_any;
    logic                 ret;
    logic                 spurious;
    logic                 burst_end;
    logic [NUM_PORTS-1:0] exp_en;

    // Returns {found, index} of the first request at or after ptr, wrapping.
    function automatic logic [IW:0] rr_pick(
        input logic [NUM_PORTS-1:0] req,
        input logic [IW-1:0]        ptr
    );
        logic [IW:0]   res;
        logic [IW-1:0] j;
        int            idx;
        res = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_PORTS;
            j   = IW'(idx);
            if (req[j]) res = {1'b1, j};
        end
        return res;
    endfunction

    assign pick    = rr_pick(req_i, ptr_q);
    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = buf_q[rd_ptr_q];
    assign err_o   = err_q;
    assign drain   = valid_o & ready_i;
    assign load    = 3'(cnt_q) + 3'(inflight_q);
    assign credit  = (load - 3'(drain)) < 3'd2;
    assign pop_any = (state_q == GRANT) & req_i[owner_q] & credit;

    // Returns are matched to the recorded source, not the current owner.
    assign exp_en   = inflight_q ? (NUM_PORTS'(1) << src_q) : '0;
    assign ret      = armed_q & inflight_q & en_i[src_q];
    assign spurious = armed_q & (|(en_i & ~exp_en));

`ifdef NOC_ARB_BURST_LIMIT_EN
    assign burst_end = pop_any & (burst_q == BW'(MAX_BURST - 1));
`else
    assign burst_end = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        burst_d = burst_q;
        unique case (state_q)
            IDLE: begin
                if (pick[IW]) begin
                    owner_d = pick[IW-1:0];
                    ptr_d   = (pick[IW-1:0] == IW'(NUM_PORTS - 1)) ?
                              '0 : pick[IW-1:0] + 1'b1;
                    burst_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (pop_any) burst_d = burst_q + 1'b1;
                if (!req_i[owner_q] || burst_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop_o   = '0;
        grant_o = '0;
        if (state_q == GRANT) begin
            grant_o[owner_q] = 1'b1;
            pop_o[owner_q]   = pop_any;
        end
    end

    assign inflight_d = pop_any | (inflight_q & ~ret);
    assign src_d      = pop_any ? owner_q : src_q;
    assign err_d      = err_q | spurious;
    assign cnt_d      = cnt_q + 2'(ret) - 2'(drain);

    // armed_q stays low for the first cycle after reset so a stale return is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            src_q      <= '0;
            armed_q    <= 1'b0;
            err_q      <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            src_q      <= src_d;
            armed_q    <= 1'b1;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            if (ret) begin
                buf_q[wr_ptr_q] <= data_i[src_q*DATA_W +: DATA_W];
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (drain) rd_ptr_q <= ~rd_ptr_q;
        end
    end

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Bench for noc_out_port_arbiter: queue model answers pops one cycle later,
// returned flits go to a scoreboard queue and are compared on each downstream accept.
module tb_noc_out_port_arbiter;
    localparam int DW = 16;
    localparam int NP = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    req_i, en_i, pop_o, grant_o;
    logic [NP*DW-1:0] data_i;
    logic [DW-1:0]    data_o;
    logic             valid_o, ready_i, err_o;

    noc_out_port_arbiter #(
        .DATA_W   (DW),
        .NUM_PORTS(NP),
        .MAX_BURST(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req_i),
        .en_i   (en_i),
        .data_i (data_i),
        .pop_o  (pop_o),
        .data_o (data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .grant_o(grant_o),
        .err_o  (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rdy;
        logic [NP-1:0] grant;
        logic [NP-1:0] pop;
        logic          vld;
        logic [DW-1:0] data;
    } vec_t;

    int            n_chk = 0;
    int            n_pass = 0;
    int            flits = 0;
    int            rem [NP];
    logic [DW-1:0] nxt [NP];
    logic [NP-1:0] pend, spur;
    logic [DW-1:0] exp_q [$];
    logic [NP-1:0] s_pop, s_grant;
    logic          s_vld, s_err;
    logic [DW-1:0] s_data;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, want);
    endtask

    task automatic model_clear();
        for (int n = 0; n < NP; n++) begin
            rem[n] = 0;
            nxt[n] = '0;
        end
        pend = '0;
        spur = '0;
        exp_q.delete();
    endtask

    // One clock cycle: drive queue returns, sample outputs, advance past the edge.
    task automatic tick();
        en_i = pend | spur;
        for (int n = 0; n < NP; n++) begin
            req_i[n] = (rem[n] > 0);
            if (pend[n]) begin
                data_i[n*DW +: DW] = nxt[n];
                exp_q.push_back(nxt[n]);
                nxt[n] = nxt[n] + 16'h1;
            end else begin
                data_i[n*DW +: DW] = '0;
            end
        end
        spur = '0;
        #1;
        s_pop   = pop_o;
        s_grant = grant_o;
        s_vld   = valid_o;
        s_err   = err_o;
        s_data  = data_o;
        if (valid_o && ready_i) begin
            flits++;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL extra_flit: got %0h with none expected", data_o);
            end else begin
                check("flit", 32'(data_o), 32'(exp_q.pop_front()));
            end
        end
        for (int n = 0; n < NP; n++)
            if (pop_o[n]) rem[n]--;
        pend = pop_o;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_i = '0;
        en_i = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        vec_t t1 [8];
        int   npop;
        int   f0;

        t1[0] = '{1'b1, 5'b00000, 5'b00000, 1'b0, 16'h0000};
        t1[1] = '{1'b1, 5'b00100, 5'b00100, 1'b0, 16'h0000};
        t1[2] = '{1'b1, 5'b00100, 5'b00100, 1'b0, 16'h0000};
        t1[3] = '{1'b1, 5'b00100, 5'b00100, 1'b1, 16'hA001};
        t1[4] = '{1'b1, 5'b00100, 5'b00100, 1'b1, 16'hA002};
        t1[5] = '{1'b1, 5'b00100, 5'b00000, 1'b1, 16'hA003};
        t1[6] = '{1'b1, 5'b00000, 5'b00000, 1'b1, 16'hA004};
        t1[7] = '{1'b1, 5'b00000, 5'b00000, 1'b0, 16'h0000};

        rst = 1'b1;
        req_i = '0;
        en_i = '0;
        data_i = '0;
        ready_i = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        check("rst_pop", 32'(pop_o), 0);
        check("rst_grant", 32'(grant_o), 0);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_data", 32'(data_o), 0);
        check("rst_err", 32'(err_o), 0);
        rst = 1'b0;
        tick();

        // single requester, table driven
        rem[2] = 4;
        nxt[2] = 16'hA001;
        for (int i = 0; i < 8; i++) begin
            ready_i = t1[i].rdy;
            tick();
            check($sformatf("t1_grant_c%0d", i), 32'(s_grant), 32'(t1[i].grant));
            check($sformatf("t1_pop_c%0d", i), 32'(s_pop), 32'(t1[i].pop));
            check($sformatf("t1_valid_c%0d", i), 32'(s_vld), 32'(t1[i].vld));
            if (t1[i].vld)
                check($sformatf("t1_data_c%0d", i), 32'(s_data), 32'(t1[i].data));
        end
        check("t1_sb_empty", exp_q.size(), 0);

        // backpressure on port 3
        rem[3] = 6;
        nxt[3] = 16'hB001;
        npop = 0;
        f0 = flits;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (s_pop[3]) npop++;
        end
        ready_i = 1'b0;
        for (int i = 3; i < 8; i++) begin
            tick();
            if (s_pop[3]) npop++;
            check($sformatf("bp_valid_c%0d", i), 32'(s_vld), 1);
            check($sformatf("bp_data_c%0d", i), 32'(s_data), 32'h0000B001);
        end
        check("bp_pops", npop, 2);
        ready_i = 1'b1;
        tick();
        check("bp_pop_on_drain", 32'(s_pop), 32'b01000);
        run(12);
        check("bp_flits", flits - f0, 6);
        check("bp_sb_empty", exp_q.size(), 0);

        // request drop with a pop in flight
        rem[1] = 1;
        nxt[1] = 16'hC001;
        tick();
        tick();
        check("drop_pop1", 32'(s_pop), 32'b00010);
        rem[0] = 2;
        nxt[0] = 16'hD001;
        tick();
        check("drop_exit_grant", 32'(s_grant), 32'b00010);
        check("drop_exit_pop", 32'(s_pop), 0);
        run(8);
        check("drop_port0_served", rem[0], 0);
        check("drop_sb_empty", exp_q.size(), 0);
        check("drop_err", 32'(err_o), 0);

        // spurious return
        run(2);
        spur = 5'b01000;
        tick();
        tick();
        check("spur_valid", 32'(s_vld), 0);
        check("spur_err", 32'(s_err), 1);
        run(3);
        check("spur_err_sticky", 32'(s_err), 1);
        check("spur_sb_empty", exp_q.size(), 0);

        // reset with a return pending
        rem[4] = 3;
        nxt[4] = 16'hE001;
        tick();
        tick();
        check("mid_pop4", 32'(s_pop), 32'b10000);
        rst = 1'b1;
        #1;
        check("mid_rst_grant", 32'(grant_o), 0);
        check("mid_rst_pop", 32'(pop_o), 0);
        check("mid_rst_err", 32'(err_o), 0);
        #1;
        rst = 1'b0;
        spur = pend;
        pend = '0;
        for (int n = 0; n < NP; n++) rem[n] = 0;
        exp_q.delete();
        tick();
        tick();
        check("mid_stale_err", 32'(s_err), 0);
        check("mid_stale_valid", 32'(s_vld), 0);

`ifdef NOC_ARB_BURST_LIMIT_EN
        begin : rr_test
            vec_t trr [12];
            trr[0]  = '{1'b1, 5'b00000, 5'b00000, 1'b0, 16'h0};
            trr[1]  = '{1'b1, 5'b00001, 5'b00001, 1'b0, 16'h0};
            trr[2]  = '{1'b1, 5'b00001, 5'b00001, 1'b0, 16'h0};
            trr[3]  = '{1'b1, 5'b00000, 5'b00000, 1'b0, 16'h0};
            trr[4]  = '{1'b1, 5'b00010, 5'b00010, 1'b0, 16'h0};
            trr[5]  = '{1'b1, 5'b00010, 5'b00010, 1'b0, 16'h0};
            trr[6]  = '{1'b1, 5'b00000, 5'b00000, 1'b0, 16'h0};
            trr[7]  = '{1'b1, 5'b10000, 5'b10000, 1'b0, 16'h0};
            trr[8]  = '{1'b1, 5'b10000, 5'b10000, 1'b0, 16'h0};
            trr[9]  = '{1'b1, 5'b00000, 5'b00000, 1'b0, 16'h0};
            trr[10] = '{1'b1, 5'b00001, 5'b00001, 1'b0, 16'h0};
            trr[11] = '{1'b1, 5'b00001, 5'b00001, 1'b0, 16'h0};
            do_reset();
            rem[0] = 10;
            rem[1] = 10;
            rem[4] = 10;
            nxt[0] = 16'h1001;
            nxt[1] = 16'h1101;
            nxt[4] = 16'h1401;
            for (int i = 0; i < 12; i++) begin
                ready_i = trr[i].rdy;
                tick();
                check($sformatf("rr_grant_c%0d", i), 32'(s_grant), 32'(trr[i].grant));
                check($sformatf("rr_pop_c%0d", i), 32'(s_pop), 32'(trr[i].pop));
            end
            for (int n = 0; n < NP; n++) rem[n] = 0;
            run(8);
            check("rr_sb_empty", exp_q.size(), 0);
        end
`else
        begin : hold_test
            do_reset();
            rem[0] = 20;
            rem[1] = 3;
            nxt[0] = 16'hF001;
            nxt[1] = 16'hF101;
            tick();
            for (int i = 1; i <= 20; i++) begin
                tick();
                check($sformatf("hold_pop0_c%0d", i), 32'(s_pop), 32'b00001);
            end
            tick();
            check("hold_exit_grant", 32'(s_grant), 32'b00001);
            check("hold_exit_pop", 32'(s_pop), 0);
            tick();
            check("hold_idle_grant", 32'(s_grant), 0);
            tick();
            check("hold_grant1", 32'(s_grant), 32'b00010);
            check("hold_pop1", 32'(s_pop), 32'b00010);
            run(10);
            check("hold_sb_empty", exp_q.size(), 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
